// File: rtl/ibex_rf_wb_queue.sv
// Writeback queue and load scoreboard in front of the register file write port.
// Define IBEX_WBQ_FWD_EN to forward queued/returning data to the read ports.
module ibex_rf_wb_queue #(
  parameter int unsigned DataWidth = 32,
  parameter bit          RV32E     = 1'b0,
  parameter int unsigned Depth     = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 ex_valid_i,
  output logic                 ex_ready_o,
  input  logic [4:0]           ex_waddr_i,
  input  logic [DataWidth-1:0] ex_wdata_i,
  input  logic                 lsu_issue_i,
  input  logic [4:0]           lsu_issue_waddr_i,
  output logic                 lsu_issue_stall_o,
  input  logic                 lsu_valid_i,
  input  logic [4:0]           lsu_waddr_i,
  input  logic [DataWidth-1:0] lsu_wdata_i,
  output logic                 rf_we_o,
  output logic [4:0]           rf_waddr_o,
  output logic [DataWidth-1:0] rf_wdata_o,
  input  logic [4:0]           raddr_a_i,
  input  logic [4:0]           raddr_b_i,
  output logic                 hazard_a_o,
  output logic                 hazard_b_o,
  output logic                 fwd_a_o,
  output logic                 fwd_b_o,
  output logic [DataWidth-1:0] fwd_a_data_o,
  output logic [DataWidth-1:0] fwd_b_data_o,
  output logic                 err_o
);

  localparam int unsigned NumWords = RV32E ? 16 : 32;
  localparam int unsigned AW = RV32E ? 4 : 5;
  localparam int unsigned PW = $clog2(Depth);
  localparam int unsigned CW = $clog2(Depth + 1);
  localparam logic [PW:0] DepthP = (PW+1)'(Depth);
  localparam logic [CW-1:0] DepthC = CW'(Depth);

  function automatic logic [AW-1:0] ra(input logic [4:0] a);
    return a[AW-1:0];
  endfunction

  function automatic logic [PW-1:0] wrap(input logic [PW:0] v);
    logic [PW:0] t;
    t = (v >= DepthP) ? (v - DepthP) : v;
    return t[PW-1:0];
  endfunction

  logic [4:0]           waddr_q [Depth];
  logic [DataWidth-1:0] wdata_q [Depth];
  logic [PW-1:0]        head_q, head_d;
  logic [PW-1:0]        tail_q, tail_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [NumWords-1:0]  pend_q, pend_d;

  logic          full, empty, push, pop;
  logic          ex_nz, lsu_nz, iss_nz, a_nz, b_nz;
  logic          iss_hit, qm_a, qm_b, lm_a, lm_b;
  logic [PW-1:0] off_idx [Depth];
  logic [Depth-1:0] off_vld;

  assign full   = (cnt_q == DepthC);
  assign empty  = (cnt_q == '0);
  assign ex_nz  = (ra(ex_waddr_i) != '0);
  assign lsu_nz = (ra(lsu_waddr_i) != '0);
  assign iss_nz = (ra(lsu_issue_waddr_i) != '0);
  assign a_nz   = (ra(raddr_a_i) != '0);
  assign b_nz   = (ra(raddr_b_i) != '0);

  assign ex_ready_o = !full && !pend_q[ra(ex_waddr_i)];
  assign push       = ex_valid_i && ex_ready_o && ex_nz;
  assign pop        = !lsu_valid_i && !empty;
  assign err_o      = lsu_valid_i && lsu_nz &&
                      !pend_q[ra(lsu_waddr_i)];

  assign lm_a = lsu_valid_i &&
                (ra(lsu_waddr_i) == ra(raddr_a_i));
  assign lm_b = lsu_valid_i &&
                (ra(lsu_waddr_i) == ra(raddr_b_i));

  // Offset o from the head is the o-th oldest entry.
  always_comb begin
    for (int o = 0; o < Depth; o++) begin
      off_idx[o] = wrap({1'b0, head_q} + (PW+1)'(o));
      off_vld[o] = (CW'(o) < cnt_q);
    end
  end

`ifdef IBEX_WBQ_FWD_EN
  logic [DataWidth-1:0] qd_a, qd_b;
`endif

  always_comb begin
    iss_hit = 1'b0;
    qm_a    = 1'b0;
    qm_b    = 1'b0;
`ifdef IBEX_WBQ_FWD_EN
    qd_a    = '0;
    qd_b    = '0;
`endif
    for (int o = 0; o < Depth; o++) begin
      if (off_vld[o]) begin
        if (ra(waddr_q[off_idx[o]]) == ra(lsu_issue_waddr_i))
          iss_hit = 1'b1;
        if (ra(waddr_q[off_idx[o]]) == ra(raddr_a_i)) begin
          qm_a = 1'b1;
`ifdef IBEX_WBQ_FWD_EN
          qd_a = wdata_q[off_idx[o]];
`endif
        end
        if (ra(waddr_q[off_idx[o]]) == ra(raddr_b_i)) begin
          qm_b = 1'b1;
`ifdef IBEX_WBQ_FWD_EN
          qd_b = wdata_q[off_idx[o]];
`endif
        end
      end
    end
  end

  assign lsu_issue_stall_o = iss_nz && iss_hit;

`ifdef IBEX_WBQ_FWD_EN
  assign hazard_a_o = a_nz && pend_q[ra(raddr_a_i)];
  assign hazard_b_o = b_nz && pend_q[ra(raddr_b_i)];
  assign fwd_a_o    = a_nz && (lm_a || qm_a);
  assign fwd_b_o    = b_nz && (lm_b || qm_b);
  // The LSU return is younger than anything still queued.
  assign fwd_a_data_o = !a_nz ? '0 :
                        lm_a  ? lsu_wdata_i : qd_a;
  assign fwd_b_data_o = !b_nz ? '0 :
                        lm_b  ? lsu_wdata_i : qd_b;
`else
  assign hazard_a_o = a_nz &&
                      (pend_q[ra(raddr_a_i)] || qm_a || lm_a);
  assign hazard_b_o = b_nz &&
                      (pend_q[ra(raddr_b_i)] || qm_b || lm_b);
  assign fwd_a_o      = 1'b0;
  assign fwd_b_o      = 1'b0;
  assign fwd_a_data_o = '0;
  assign fwd_b_data_o = '0;
`endif

  always_comb begin
    rf_we_o    = 1'b0;
    rf_waddr_o = '0;
    rf_wdata_o = '0;
    if (lsu_valid_i) begin
      if (lsu_nz) begin
        rf_we_o    = 1'b1;
        rf_waddr_o = lsu_waddr_i;
        rf_wdata_o = lsu_wdata_i;
      end
    end else if (!empty) begin
      rf_we_o    = 1'b1;
      rf_waddr_o = waddr_q[head_q];
      rf_wdata_o = wdata_q[head_q];
    end
  end

  always_comb begin
    head_d = pop  ? wrap({1'b0, head_q} + 1'b1) : head_q;
    tail_d = push ? wrap({1'b0, tail_q} + 1'b1) : tail_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // A same-cycle issue to the returning register keeps it pending.
  always_comb begin
    pend_d = pend_q;
    if (lsu_valid_i)
      pend_d[ra(lsu_waddr_i)] = 1'b0;
    if (lsu_issue_i && !lsu_issue_stall_o && iss_nz)
      pend_d[ra(lsu_issue_waddr_i)] = 1'b1;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      pend_q <= '0;
      for (int i = 0; i < Depth; i++) begin
        waddr_q[i] <= '0;
        wdata_q[i] <= '0;
      end
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
      if (push) begin
        waddr_q[tail_q] <= ex_waddr_i;
        wdata_q[tail_q] <= ex_wdata_i;
      end
    end
  end

endmodule
